// File: rtl/alioth_alu_pkg.sv
// Shared ALU definitions for the execute-stage scheduler and its ALU.
// Holds the one-hot opcode bit positions (add is the MSB, jump the LSB),
// the packed request record that travels from a requester into the ALU,
// and the output-stage state encoding.
package alioth_alu_pkg;

    localparam int OP_W     = 13;
    localparam int OP_ADD   = 12;
    localparam int OP_SUB   = 11;
    localparam int OP_SLL   = 10;
    localparam int OP_SLT   = 9;
    localparam int OP_SLTU  = 8;
    localparam int OP_XOR   = 7;
    localparam int OP_SRL   = 6;
    localparam int OP_SRA   = 5;
    localparam int OP_OR    = 4;
    localparam int OP_AND   = 3;
    localparam int OP_LUI   = 2;
    localparam int OP_AUIPC = 1;
    localparam int OP_JUMP  = 0;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [31:0]     op1;
        logic [31:0]     op2;
        logic [4:0]      rd;
    } alu_req_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/exu_alu.sv
// Combinational integer ALU.
// Ports:
//   req_alu    - one of the arithmetic/logic op bits (add..auipc) is set
//   jump       - jump op: writes the link value op1 + op2
//   int_assert - kill: forces result and write enable to zero
//   op         - one-hot opcode (bit positions from alioth_alu_pkg)
//   op1, op2   - operands; shift amount is op2[4:0]
//   res        - result
//   we         - write enable
// The opcode is one-hot, so the result is an AND-OR of every candidate.
// lui passes op2 through (the immediate arrives pre-shifted); auipc and
// jump are plain op1 + op2 with op1 carrying the pc.
module exu_alu
    import alioth_alu_pkg::*;
(
    input  logic            req_alu,
    input  logic            jump,
    input  logic            int_assert,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     op1,
    input  logic [31:0]     op2,
    output logic [31:0]     res,
    output logic            we
);

    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [4:0]  shamt_s;
    logic [31:0] raw_s;
    logic        kill_s;

    assign sum_s   = op1 + op2;
    assign diff_s  = op1 - op2;
    assign shamt_s = op2[4:0];
    assign kill_s  = int_assert;

    // Select the result of whichever one-hot op bit is set.
    always_comb begin
        raw_s = ({32{op[OP_ADD]}}   & sum_s)
              | ({32{op[OP_SUB]}}   & diff_s)
              | ({32{op[OP_SLL]}}   & (op1 << shamt_s))
              | ({32{op[OP_SLT]}}   & {31'd0, ($signed(op1) < $signed(op2))})
              | ({32{op[OP_SLTU]}}  & {31'd0, (op1 < op2)})
              | ({32{op[OP_XOR]}}   & (op1 ^ op2))
              | ({32{op[OP_SRL]}}   & (op1 >> shamt_s))
              | ({32{op[OP_SRA]}}   & 32'($signed(op1) >>> shamt_s))
              | ({32{op[OP_OR]}}    & (op1 | op2))
              | ({32{op[OP_AND]}}   & (op1 & op2))
              | ({32{op[OP_LUI]}}   & op2)
              | ({32{op[OP_AUIPC]}} & sum_s)
              | ({32{jump}}         & sum_s);
        res = kill_s ? 32'd0 : raw_s;
        we  = (req_alu | jump) & ~kill_s;
    end

endmodule

// File: rtl/exu_alu_sched.sv
// Two-requester ALU scheduler with a single registered write-back stage.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o - requester N handshake (N = 0, 1)
//   reqN_op_i/op1_i/op2_i/rd_i  - one-hot op, operands, destination
//   int_assert_i                - flush: blocks accepts, drops held result
//   wb_valid_o / wb_ready_i     - write-back handshake
//   wb_data_o/rd_o/we_o/src_o   - held result, rd, write enable, source
//   issue_cnt_o                 - wrapping count of accepted ops
// RR_EN = 1 alternates on ties; RR_EN = 0 always favours requester 0.
module exu_alu_sched
    import alioth_alu_pkg::*;
#(
    parameter logic RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [OP_W-1:0] req0_op_i,
    input  logic [31:0]     req0_op1_i,
    input  logic [31:0]     req0_op2_i,
    input  logic [4:0]      req0_rd_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [OP_W-1:0] req1_op_i,
    input  logic [31:0]     req1_op1_i,
    input  logic [31:0]     req1_op2_i,
    input  logic [4:0]      req1_rd_i,
    input  logic            int_assert_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [31:0]     wb_data_o,
    output logic [4:0]      wb_rd_o,
    output logic            wb_we_o,
    output logic            wb_src_o,
    output logic [15:0]     issue_cnt_o
);

    wb_state_t   state_r;
    wb_state_t   state_nxt_s;
    logic        last_grant_r;
    logic        grant0_s;
    logic        grant1_s;
    logic        can_accept_s;
    logic        accept_s;
    alu_req_t    req0_s;
    alu_req_t    req1_s;
    alu_req_t    sel_s;
    logic        req_alu_s;
    logic [31:0] alu_res_s;
    logic        alu_we_s;

    assign req0_s = {req0_op_i, req0_op1_i, req0_op2_i, req0_rd_i};
    assign req1_s = {req1_op_i, req1_op1_i, req1_op2_i, req1_rd_i};

    // Grant: a lone requester wins; on a tie alternate or favour req0.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            if (RR_EN && (last_grant_r == 1'b0)) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (req0_valid_i) begin
            grant0_s = 1'b1;
        end else if (req1_valid_i) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Readies come only from grant, stage occupancy and wb_ready_i, never
    // from the result path; rst_n keeps them low throughout reset.
    assign can_accept_s = (state_r == ST_EMPTY) || wb_ready_i;
    assign req0_ready_o = grant0_s & can_accept_s & ~int_assert_i & rst_n;
    assign req1_ready_o = grant1_s & can_accept_s & ~int_assert_i & rst_n;
    assign accept_s     = req0_ready_o | req1_ready_o;

    assign sel_s     = grant1_s ? req1_s : req0_s;
    assign req_alu_s = |sel_s.op[OP_ADD:OP_AUIPC];

    exu_alu u_alu (
        .req_alu    (req_alu_s),
        .jump       (sel_s.op[OP_JUMP]),
        .int_assert (1'b0),
        .op         (sel_s.op),
        .op1        (sel_s.op1),
        .op2        (sel_s.op2),
        .res        (alu_res_s),
        .we         (alu_we_s)
    );

    // Output-stage next state: flush beats accept, accept beats drain.
    always_comb begin
        state_nxt_s = state_r;
        if (int_assert_i) begin
            state_nxt_s = ST_EMPTY;
        end else if (accept_s) begin
            state_nxt_s = ST_FULL;
        end else if ((state_r == ST_FULL) && wb_ready_i) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign wb_valid_o = (state_r == ST_FULL);

    // Result payload, arbitration history and issue counter; all change
    // only on an accept, so a flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_o    <= 32'd0;
            wb_rd_o      <= 5'd0;
            wb_we_o      <= 1'b0;
            wb_src_o     <= 1'b0;
            last_grant_r <= 1'b1;
            issue_cnt_o  <= 16'd0;
        end else if (accept_s) begin
            wb_data_o    <= alu_res_s;
            wb_rd_o      <= sel_s.rd;
            wb_we_o      <= alu_we_s & (sel_s.rd != 5'd0);
            wb_src_o     <= grant1_s;
            last_grant_r <= grant1_s;
            issue_cnt_o  <= issue_cnt_o + 16'd1;
        end else begin
            wb_data_o    <= wb_data_o;
            wb_rd_o      <= wb_rd_o;
            wb_we_o      <= wb_we_o;
            wb_src_o     <= wb_src_o;
            last_grant_r <= last_grant_r;
            issue_cnt_o  <= issue_cnt_o;
        end
    end

endmodule

// File: tb/tb_exu_alu_sched.sv
// Scoreboard bench for exu_alu_sched. Stimulus pushes the hand-computed
// write-back expected for each accept; a negedge monitor pops and compares
// whenever a write-back handshake is presented. A second instance with
// RR_EN = 0 shares the inputs and is checked for fixed priority.
module tb_exu_alu_sched;
    import alioth_alu_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        src;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid_i, req1_valid_i, int_assert_i, wb_ready_i;
    logic [OP_W-1:0] req0_op_i, req1_op_i;
    logic [31:0]     req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
    logic [4:0]      req0_rd_i, req1_rd_i;

    logic        req0_ready_o, req1_ready_o, wb_valid_o, wb_we_o, wb_src_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic [15:0] issue_cnt_o;

    logic        r0_b, r1_b, valid_b, we_b, src_b;
    logic [31:0] data_b;
    logic [4:0]  rd_b;
    logic [15:0] cnt_b;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp0_data, exp1_data;
    logic        exp0_we, exp1_we;

    always #5 clk = ~clk;

    exu_alu_sched #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_op_i(req0_op_i), .req0_op1_i(req0_op1_i),
        .req0_op2_i(req0_op2_i), .req0_rd_i(req0_rd_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_op_i(req1_op_i), .req1_op1_i(req1_op1_i),
        .req1_op2_i(req1_op2_i), .req1_rd_i(req1_rd_i),
        .int_assert_i(int_assert_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o),
        .wb_src_o(wb_src_o), .issue_cnt_o(issue_cnt_o)
    );

    exu_alu_sched #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(r0_b),
        .req0_op_i(req0_op_i), .req0_op1_i(req0_op1_i),
        .req0_op2_i(req0_op2_i), .req0_rd_i(req0_rd_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(r1_b),
        .req1_op_i(req1_op_i), .req1_op1_i(req1_op1_i),
        .req1_op2_i(req1_op2_i), .req1_rd_i(req1_rd_i),
        .int_assert_i(int_assert_i),
        .wb_valid_o(valid_b), .wb_ready_i(wb_ready_i),
        .wb_data_o(data_b), .wb_rd_o(rd_b), .wb_we_o(we_b),
        .wb_src_o(src_b), .issue_cnt_o(cnt_b)
    );

    function automatic logic [OP_W-1:0] oh(input int idx);
        oh = 13'd1 << idx;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every write-back handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid_o && wb_ready_i) begin
            chk("wb_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_result", {wb_data_o, wb_rd_o, wb_we_o, wb_src_o},
                    {e.data, e.rd, e.we, e.src});
            end
        end
    end

    // Drive one cycle's inputs, check readies at the negedge, push accepts.
    task automatic step(input logic v0, input logic v1, input logic wr,
                        input logic intr, input logic er0, input logic er1);
        req0_valid_i = v0;
        req1_valid_i = v1;
        wb_ready_i   = wr;
        int_assert_i = intr;
        @(negedge clk);
        chk("req0_ready", 64'(req0_ready_o), 64'(er0));
        chk("req1_ready", 64'(req1_ready_o), 64'(er1));
        if (er0) sb_q.push_back(exp_t'({exp0_data, req0_rd_i, exp0_we, 1'b0}));
        if (er1) sb_q.push_back(exp_t'({exp1_data, req1_rd_i, exp1_we, 1'b1}));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic wr,
                         input logic intr, input logic er0, input logic er1);
        step(v0, v1, wr, intr, er0, er1);
        adv();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_payload"}, {wb_data_o, wb_rd_o, wb_we_o, wb_src_o}, 64'd0);
        chk({tag, "_cnt"}, 64'(issue_cnt_o), 64'd0);
        chk({tag, "_readies"}, {r0_b, r1_b, req0_ready_o, req1_ready_o}, 64'd0);
    endtask

    task automatic set_add_sub();
        req0_op_i = oh(OP_ADD); req0_op1_i = 32'd5;  req0_op2_i = 32'd7;
        req0_rd_i = 5'd3; exp0_data = 32'd12; exp0_we = 1'b1;
        req1_op_i = oh(OP_SUB); req1_op1_i = 32'd10; req1_op2_i = 32'd3;
        req1_rd_i = 5'd4; exp1_data = 32'd7;  exp1_we = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        int_assert_i = 1'b0; wb_ready_i = 1'b1;
        set_add_sub();
        #1 rst_n = 1'b0;
        #3 check_reset_outputs("reset");
        adv(); adv();
        rst_n = 1'b1;

        // Round-robin on a tie, first tie goes to req0.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, i % 2 == 0, i % 2 == 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rr_cnt", 64'(issue_cnt_o), 64'd4);

        // Back-pressure: result held, ready low, accept on the drain cycle.
        req0_op_i = oh(OP_XOR); req0_op1_i = 32'hF0F0_0000; req0_op2_i = 32'h0FF0_0000;
        req0_rd_i = 5'd5; exp0_data = 32'hFF00_0000; exp0_we = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("hold_data", {31'd0, wb_valid_o, wb_data_o}, {32'd1, 32'hFF00_0000});
            adv();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_cnt", 64'(issue_cnt_o), 64'd6);

        // Flush while FULL drops the held sra result.
        req0_op_i = oh(OP_SRA); req0_op1_i = 32'h8000_0000; req0_op2_i = 32'd4;
        req0_rd_i = 5'd6; exp0_data = 32'hF800_0000; exp0_we = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sra_full", {31'd0, wb_valid_o, wb_data_o}, {32'd1, 32'hF800_0000});
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_valid", 64'(wb_valid_o), 64'd0);
        chk("flush_pending", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        adv();
        chk("flush_cnt", 64'(issue_cnt_o), 64'd7);

        // rd = 0 suppresses write enable; jump link; zero op; compares; shift.
        req0_op_i = oh(OP_JUMP); req0_op1_i = 32'h100; req0_op2_i = 32'd4;
        req0_rd_i = 5'd1; exp0_data = 32'h104; exp0_we = 1'b1;
        req1_op_i = oh(OP_OR); req1_op1_i = 32'd1; req1_op2_i = 32'd2;
        req1_rd_i = 5'd0; exp1_data = 32'd3; exp1_we = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        req0_op_i = 13'd0; req0_op1_i = 32'h55; req0_op2_i = 32'hAA;
        req0_rd_i = 5'd7; exp0_data = 32'd0; exp0_we = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        req1_op_i = oh(OP_SLT); req1_op1_i = 32'hFFFF_FFFF; req1_op2_i = 32'd1;
        req1_rd_i = 5'd8; exp1_data = 32'd1; exp1_we = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        req0_op_i = oh(OP_SLL); req0_op1_i = 32'd3; req0_op2_i = 32'd33;
        req0_rd_i = 5'd9; exp0_data = 32'd6; exp0_we = 1'b1;
        req1_op_i = oh(OP_SLTU); req1_rd_i = 5'd10; exp1_data = 32'd0; exp1_we = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("misc_cnt", 64'(issue_cnt_o), 64'd13);

        // Counter wrap, then reset while FULL.
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        set_add_sub();
        for (int i = 0; i < 65535; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("cnt_max", 64'(issue_cnt_o), 64'hFFFF);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("cnt_wrap", 64'(issue_cnt_o), 64'd0);
        req0_valid_i = 1'b1; req1_valid_i = 1'b1; wb_ready_i = 1'b0;
        chk("pre_reset_valid", {31'd0, wb_valid_o, wb_data_o}, {32'd1, 32'd12});
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        chk("midrst_pending", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        adv(); adv();
        rst_n = 1'b1;

        // Fixed priority instance keeps granting req0 on a tie.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, i % 2 == 0, i % 2 == 1);
            chk("fp_readies", {r0_b, r1_b}, 64'b10);
            if (i > 0) chk("fp_wb", {valid_b, src_b, data_b}, {1'b1, 1'b0, 32'd12});
            adv();
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fp_wb_last", {valid_b, src_b, data_b, cnt_b}, {1'b1, 1'b0, 32'd12, 16'd3});
        adv();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
